// File: rtl/i2c_slave_target.sv
// Clock-oversampled I2C target: synchronizes SCL/SDA, matches a 7-bit address,
// receives write bytes or transmits read bytes, and drives SDA open-drain only.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw_flag,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK,
    S_WAIT_STOP
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic                byte_done, byte_done_nxt;
  logic                ack_on, ack_on_nxt;
  logic [BYTE_W-1:0]   shreg, shreg_nxt;
  logic                sda_low, sda_low_nxt;
  logic [BYTE_W-1:0]   rx_data_nxt;
  logic                rx_valid_nxt;
  logic                tx_req_nxt;
  logic                rw_flag_nxt;
  logic                busy_nxt;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [BYTE_W-1:0] shift_in;

  // Open-drain pad: pull low or release, never drive high.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign shift_in  = {shreg[BYTE_W-2:0], sda_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      ack_on    <= 1'b0;
      shreg     <= '0;
      sda_low   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw_flag   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_done <= byte_done_nxt;
      ack_on    <= ack_on_nxt;
      shreg     <= shreg_nxt;
      sda_low   <= sda_low_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      rw_flag   <= rw_flag_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    byte_done_nxt = byte_done;
    ack_on_nxt    = ack_on;
    shreg_nxt     = shreg;
    sda_low_nxt   = sda_low;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    rw_flag_nxt   = rw_flag;
    busy_nxt      = busy;

    case (state)
      S_IDLE: begin
      end

      S_ADDR: begin
        if (scl_rise) begin
          shreg_nxt = shift_in;
          if (bit_cnt == CNT_W'(7)) begin
            bit_cnt_nxt = '0;
            ack_on_nxt  = 1'b0;
            if (shift_in[BYTE_W-1:1] == SLAVE_ADDR) begin
              rw_flag_nxt = shift_in[0];
              busy_nxt    = 1'b1;
              state_nxt   = S_ADDR_ACK;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = S_WAIT_STOP;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end

      // First fall opens the ACK slot (and fetches the first read byte),
      // second fall closes it and, for reads, puts the MSB on the bus.
      S_ADDR_ACK: begin
        if (scl_fall) begin
          if (!ack_on) begin
            ack_on_nxt  = 1'b1;
            sda_low_nxt = 1'b1;
            if (rw_flag) begin
              tx_req_nxt = 1'b1;
              shreg_nxt  = tx_data;
            end
          end else begin
            ack_on_nxt    = 1'b0;
            byte_done_nxt = 1'b0;
            if (rw_flag) begin
              sda_low_nxt = ~shreg[BYTE_W-1];
              shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
              bit_cnt_nxt = CNT_W'(1);
              state_nxt   = S_READ;
            end else begin
              sda_low_nxt = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = S_WRITE;
            end
          end
        end
      end

      S_WRITE: begin
        if (scl_rise) begin
          shreg_nxt = shift_in;
          if (bit_cnt == CNT_W'(7)) begin
            rx_data_nxt  = shift_in;
            rx_valid_nxt = 1'b1;
            bit_cnt_nxt  = '0;
            ack_on_nxt   = 1'b0;
            state_nxt    = S_WRITE_ACK;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end

      S_WRITE_ACK: begin
        if (scl_fall) begin
          if (!ack_on) begin
            ack_on_nxt  = 1'b1;
            sda_low_nxt = 1'b1;
          end else begin
            ack_on_nxt  = 1'b0;
            sda_low_nxt = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = S_WRITE;
          end
        end
      end

      // byte_done marks that all eight bits are out; the next fall frees SDA.
      S_READ: begin
        if (scl_fall) begin
          if (byte_done) begin
            sda_low_nxt   = 1'b0;
            byte_done_nxt = 1'b0;
            bit_cnt_nxt   = '0;
            ack_on_nxt    = 1'b0;
            state_nxt     = S_READ_ACK;
          end else begin
            sda_low_nxt = ~shreg[BYTE_W-1];
            shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
            if (bit_cnt == CNT_W'(7)) begin
              byte_done_nxt = 1'b1;
            end
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end

      S_READ_ACK: begin
        if (scl_rise) begin
          if (!sda_s2) begin
            ack_on_nxt = 1'b1;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = S_WAIT_STOP;
          end
        end else if (scl_fall && ack_on) begin
          tx_req_nxt    = 1'b1;
          ack_on_nxt    = 1'b0;
          sda_low_nxt   = ~tx_data[BYTE_W-1];
          shreg_nxt     = {tx_data[BYTE_W-2:0], 1'b0};
          bit_cnt_nxt   = CNT_W'(1);
          byte_done_nxt = 1'b0;
          state_nxt     = S_READ;
        end
      end

      S_WAIT_STOP: begin
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Bus conditions override everything; START takes priority over STOP.
    if (stop_det) begin
      state_nxt     = S_IDLE;
      sda_low_nxt   = 1'b0;
      busy_nxt      = 1'b0;
      ack_on_nxt    = 1'b0;
      bit_cnt_nxt   = '0;
      byte_done_nxt = 1'b0;
      rx_valid_nxt  = 1'b0;
      tx_req_nxt    = 1'b0;
    end
    if (start_det) begin
      state_nxt     = S_ADDR;
      sda_low_nxt   = 1'b0;
      ack_on_nxt    = 1'b0;
      bit_cnt_nxt   = '0;
      byte_done_nxt = 1'b0;
      rx_valid_nxt  = 1'b0;
      tx_req_nxt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-level I2C master plus a transaction model
// (expected write bytes, expected tx_req count, expected SDA ownership).
module tb_i2c_slave_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw_flag;
  logic       busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_slave_target #(.SLAVE_ADDR(7'h50)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda_bus),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rw_flag (rw_flag),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         tx_cnt = 0;
  int         exp_tx = 0;
  logic [7:0] exp_rx[$];
  logic       allow = 1'b0;
  logic       rxv_prev = 1'b0;
  int         phase = 0;  // 0 none, 1 selected write, 2 selected read, 3 not selected
  logic [7:0] got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; tgt marks a slot in which the target owns SDA.
  task automatic bit_io(input logic drv, input logic val, input logic tgt, output logic smp);
    if (tgt) allow = 1'b1;
    scl = 1'b0;
    wait_n(6);
    allow = tgt;
    m_low = drv & ~val;
    wait_n(4);
    scl = 1'b1;
    wait_n(5);
    smp = sda_bus;
    wait_n(5);
  endtask

  task automatic start_cond();
    scl = 1'b0;
    wait_n(6);
    allow = 1'b0;
    m_low = 1'b0;
    wait_n(4);
    scl = 1'b1;
    wait_n(5);
    m_low = 1'b1;
    wait_n(10);
  endtask

  task automatic stop_cond();
    scl = 1'b0;
    wait_n(6);
    allow = 1'b0;
    m_low = 1'b1;
    wait_n(4);
    scl = 1'b1;
    wait_n(5);
    m_low = 1'b0;
    wait_n(10);
    phase = 0;
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic tgt_ack, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(1'b1, b[i], 1'b0, s);
    bit_io(1'b0, 1'b0, tgt_ack, s);
    check("ack_bit", 32'(s), 32'(exp_ack));
  endtask

  task automatic send_addr(input logic [7:0] b);
    logic match;
    match = (b[7:1] == 7'h50);
    if (match && b[0]) exp_tx++;
    send_byte(b, match, ~match);
    phase = match ? (b[0] ? 2 : 1) : 3;
    if (match) check("rw_flag", 32'(rw_flag), 32'(b[0]));
    check("busy_addr", 32'(busy), 32'(match));
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic sel;
    sel = (phase == 1);
    if (sel) exp_rx.push_back(b);
    send_byte(b, sel, ~sel);
    check("busy_write", 32'(busy), 32'(sel));
  endtask

  task automatic read_byte(input logic [7:0] src, input logic mack, output logic [7:0] r);
    logic s;
    tx_data = src;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b0, 1'b0, 1'b1, s);
      r[i] = s;
    end
    bit_io(1'b1, ~mack, 1'b0, s);
    if (mack) exp_tx++;
    else phase = 3;
    check("read_byte", 32'(r), 32'(src));
    check("busy_read", 32'(busy), 32'(phase == 2));
  endtask

  // Every-cycle checks against the transaction model.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
        else check("rx_data_pulse", 32'(rx_data), 32'(exp_rx.pop_front()));
        check("rx_valid_width", 32'(rxv_prev), 32'd0);
      end
      if (tx_req) begin
        tx_cnt++;
        check("tx_req_busy", 32'(busy), 32'd1);
      end
      if (!allow) check("sda_drive", 32'(sda_bus === 1'b0 && !m_low), 32'd0);
    end
    rxv_prev = rx_valid;
  end

  initial begin
    logic s;
    wait_n(3);
    check("rst_sda", 32'(sda_bus), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_rw_flag", 32'(rw_flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_n(10);

    // Single-byte write
    start_cond();
    send_addr(8'hA0);
    write_byte(8'h3C);
    stop_cond();
    check("write_rx_data", 32'(rx_data), 32'h3C);
    check("write_rw_flag", 32'(rw_flag), 32'd0);

    // Two-byte read, ACK then NACK
    tx_data = 8'h96;
    start_cond();
    send_addr(8'hA1);
    read_byte(8'h96, 1'b1, got);
    check("read1_lit", 32'(got), 32'h96);
    read_byte(8'h5A, 1'b0, got);
    check("read2_lit", 32'(got), 32'h5A);
    check("read_sda_released", 32'(sda_bus), 32'd1);
    stop_cond();
    check("read_tx_req_cnt", 32'(tx_cnt), 32'd2);

    // Address mismatch
    start_cond();
    send_addr(8'h42);
    write_byte(8'hFF);
    check("mismatch_busy", 32'(busy), 32'd0);
    stop_cond();
    check("mismatch_tx_req_cnt", 32'(tx_cnt), 32'd2);
    check("mismatch_rx_data", 32'(rx_data), 32'h3C);

    // Write then repeated start into a read
    start_cond();
    send_addr(8'hA0);
    write_byte(8'h01);
    tx_data = 8'hC3;
    start_cond();
    send_addr(8'hA1);
    check("rs_rw_flag", 32'(rw_flag), 32'd1);
    read_byte(8'hC3, 1'b0, got);
    check("rs_read_lit", 32'(got), 32'hC3);
    stop_cond();
    check("rs_rx_data", 32'(rx_data), 32'h01);

    // STOP after four bits of a write byte, then a full write
    start_cond();
    send_addr(8'hA0);
    for (int i = 7; i >= 4; i--) bit_io(1'b1, 1'b0, 1'b0, s);
    stop_cond();
    check("abort_rx_data", 32'(rx_data), 32'h01);
    start_cond();
    send_addr(8'hA0);
    write_byte(8'h77);
    stop_cond();
    check("after_abort_rx_data", 32'(rx_data), 32'h77);

    // Asynchronous reset while the target is driving a 0 bit
    tx_data = 8'h00;
    start_cond();
    send_addr(8'hA1);
    allow = 1'b1;
    scl = 1'b0;
    wait_n(6);
    check("rr_drive_low", 32'(sda_bus), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rr_sda_release", 32'(sda_bus), 32'd1);
    check("rr_rx_data", 32'(rx_data), 32'd0);
    check("rr_rx_valid", 32'(rx_valid), 32'd0);
    check("rr_tx_req", 32'(tx_req), 32'd0);
    check("rr_rw_flag", 32'(rw_flag), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    allow = 1'b0;
    wait_n(4);
    rst = 1'b0;
    wait_n(5);
    scl = 1'b1;
    wait_n(10);
    phase = 0;
    stop_cond();

    check("tx_req_total", 32'(tx_cnt), 32'(exp_tx));
    check("rx_pending", 32'(exp_rx.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

Clock-oversampled I2C target (responder) for the bridge's serial side: the counterpart of the bridge's I2C master. Synchronizes SCL/SDA into `clk`, detects START/STOP, matches a 7-bit address, then receives write bytes or transmits read bytes. Drives SDA open-drain only, low or released. Exposes a byte-level handshake to the register/APB side.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target answers to.
- `clk`  in  1  system clock; must be ≥8× SCL rate.
- `rst`  in  1  reset; asynchronous, active-high.
- `scl`  in  1  I2C clock from master, asynchronous to `clk`.
- `sda`  inout  1  I2C data. Driven 0 when `sda_low`=1, else 1'bz.
- `tx_data`  in  8  byte to send on reads. Sampled on the `tx_req` cycle.
- `tx_req`  out  1  one-cycle pulse: `tx_data` captured for the next read byte.
- `rx_data`  out  8  last byte written by master.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rw_flag`  out  1  R/W bit of the current transaction (1 = read).
- `busy`  out  1  high from address match until STOP or NACK release.

## Operation
- Input path: 2-flop synchronizers on `scl` and `sda`, plus one delay register each for edge detection. All decisions use the synchronized values.
- START: synchronized SDA falls while SCL is high.
- STOP: synchronized SDA rises while SCL is high.
- START is honored in every state, including a repeated start. It clears the bit count, releases SDA, and enters ADDR.
- STOP is honored in every state. It releases SDA and enters IDLE.
- The data bit is sampled on each SCL rising edge. Any SDA change the target makes occurs on an SCL falling edge.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB-first (7 address bits + R/W).
    - After bit 8, if [7:1]==SLAVE_ADDR: latch `rw_flag`, set `busy`, go to ADDR_ACK.
    - On mismatch: go to WAIT_STOP; never touch SDA.
  - ADDR_ACK: drive SDA low from the next SCL fall to the following SCL fall.
    - rw=0: go to WRITE.
    - rw=1: pulse `tx_req` on the ACK-start SCL fall, load the shift register, go to READ.
  - WRITE: shift 8 bits. After the 8th SCL rise, update `rx_data`, pulse `rx_valid`, go to WRITE_ACK.
  - WRITE_ACK: drive ACK low for one SCL period, then return to WRITE for the next byte. Unlimited bytes.
  - READ: on each SCL fall, drive `sda_low` = ~bit (MSB first). After the 8th bit, release SDA on the next fall and go to READ_ACK.
  - READ_ACK: sample SDA on the SCL rise.
    - 0 (ACK): pulse `tx_req` on the next fall, reload, go to READ.
    - 1 (NACK): go to WAIT_STOP and clear `busy`.
  - WAIT_STOP: SDA released; wait for START or STOP.
- Bit counter: 3 bits plus a done flag, reset at each byte boundary. It never wraps silently into the ACK slot.

## Timing
- Reset values: `sda_low`=0 (SDA released), `rx_data`=0, `rx_valid`=0, `tx_req`=0, `rw_flag`=0, `busy`=0; state IDLE; synchronizers reset to 1.
- Input latency: 3 `clk` from pad to edge detect.
- `rx_valid` asserts 3–4 `clk` after the 8th SCL rise at the pad. It is exactly 1 cycle wide.
- `tx_data` must be stable in the `tx_req` cycle. No backpressure: the byte is used unconditionally.
- SDA transitions occur 3–4 `clk` after the SCL fall at the pad. This must fall within the master's SCL-low time.
- A START or STOP in the middle of a byte aborts the byte:
  - no `rx_valid` for the partial byte;
  - SDA is released in the same cycle the condition is detected.
- A START and an SCL edge cannot coincide, because SCL is high during START. If STOP and START are detected in the same cycle, START wins.
- Async reset mid-transfer: SDA is released immediately, the target returns to IDLE, and it ignores the bus until the next START.

## Test plan
- Write: START, 0xA0 (0x50, W), 0x3C, STOP.
  - Target ACKs both bytes.
  - `rx_data`=0x3C with one `rx_valid` pulse.
  - `rw_flag`=0; `busy` high then low after STOP.
- Read two bytes: START, 0xA1, `tx_data`=0x96 then 0x5A; master ACKs byte 1 and NACKs byte 2.
  - Bus shows 0x96 then 0x5A.
  - Exactly two `tx_req` pulses.
  - SDA released after the NACK.
- Address mismatch: START, 0x42, data 0xFF, STOP.
  - SDA never driven low.
  - No `rx_valid`, no `tx_req`, `busy`=0 throughout.
- Repeated start: write 0x01 to 0x50, then Sr, 0xA1, read 0xC3 with NACK, STOP.
  - `rx_data`=0x01; read returns 0xC3; `rw_flag` switches to 1.
- Abort: STOP after 4 bits of a write byte.
  - No `rx_valid`; state IDLE.
  - A following full write of 0x77 is received correctly.
- Reset mid-read: assert `rst` while driving a 0 bit.
  - SDA goes Z in the same cycle.
  - All outputs return to their reset values.
